dot_acc: RTL and testbench

Parametrised, fully pipelined LANES-wide signed dot-product engine with a multi-beat accumulator. It is the generalised successor of the fixed 8-lane dot-product stage. Vectors longer than LANES are streamed as consecutive beats, and the per-beat dot products are summed until a beat marked `ilast`. The block then emits one saturated result per group, together with a beat count and an overflow flag. It feeds the downstream activation/requantisation logic.

---
 rtl/dot_acc.sv | 154 +++++++++++++++
 tb/tb_dot_acc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dot_acc.sv
// dot_acc: pipelined LANES-wide signed dot product with a multi-beat,
// saturating group accumulator.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - asynchronous active-low reset
//   vec0/vec1 - packed signed operands, lane 0 in the most-significant slice
//   ivalid    - beat valid
//   ilast     - final beat of the group (qualified by ivalid)
//   result    - saturated group dot product (holds between pulses)
//   ovalid    - one-cycle pulse when a group completes
//   ocount    - number of beats in the group, saturating at all-ones
//   overflow  - saturation occurred anywhere in the group
//
// Pipeline: S0 input regs, S1 products, L adder-tree levels, accumulate
// stage, then an output register stage (last beat to ovalid = L+3 cycles).
module dot_acc #(
  parameter int unsigned IWIDTH = 8,
  parameter int unsigned LANES  = 8,
  parameter int unsigned OWIDTH = 32,
  parameter int unsigned CWIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*IWIDTH-1:0]     vec0,
  input  logic [LANES*IWIDTH-1:0]     vec1,
  input  logic                        ivalid,
  input  logic                        ilast,
  output logic signed [OWIDTH-1:0]    result,
  output logic                        ovalid,
  output logic [CWIDTH-1:0]           ocount,
  output logic                        overflow
);

  localparam int unsigned L  = $clog2(LANES);
  localparam int unsigned PW = 2 * IWIDTH;
  localparam int unsigned TW = PW + L;
  localparam int unsigned SW = OWIDTH + 1;
  localparam int unsigned NN = 2 * LANES;

  // S0 operand registers and the valid/last shift chain (index = stage)
  logic [LANES*IWIDTH-1:0] a_q, b_q;
  logic [L+1:0]            vld_q, lst_q;

  // Heap-ordered tree: leaves LANES..NN-1 hold products (S1), node i is
  // node 2i + node 2i+1, root is node 1. Each depth is one register stage.
  logic signed [TW-1:0] node_q [1:NN-1];
  logic signed [TW-1:0] node_d [1:NN-1];
  logic signed [PW-1:0] prod_c [LANES];

  // Accumulator state
  logic signed [OWIDTH-1:0] acc_q, acc_d;
  logic [CWIDTH-1:0]        cnt_q, cnt_d;
  logic                     sat_q, sat_d;
  logic                     first_q, first_d;
  logic                     done_q, done_d;

  logic signed [OWIDTH-1:0] base_c;
  logic [CWIDTH-1:0]        cnt_base_c;
  logic signed [SW-1:0]     sum_c;
  logic                     ovf_c;

  // Products and tree sums
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      prod_c[i] = PW'($signed(a_q[(int'(LANES)-1-i)*int'(IWIDTH) +: IWIDTH]))
                * PW'($signed(b_q[(int'(LANES)-1-i)*int'(IWIDTH) +: IWIDTH]));
      node_d[int'(LANES)+i] = TW'(prod_c[i]);
    end
    for (int i = 1; i < int'(LANES); i++) begin
      node_d[i] = node_q[2*i] + node_q[2*i+1];
    end
  end

  // Accumulate with clamp; a new group starts from zero when first_q is set
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    first_d = first_q;
    done_d  = 1'b0;

    base_c     = first_q ? '0 : acc_q;
    cnt_base_c = first_q ? '0 : cnt_q;
    sum_c      = SW'(base_c) + SW'(node_q[1]);
    // Top two bits disagree exactly when the sum is outside OWIDTH range
    ovf_c      = sum_c[SW-1] ^ sum_c[SW-2];

    if (vld_q[L+1]) begin
      if (ovf_c) begin
        acc_d = sum_c[SW-1] ? {1'b1, {(OWIDTH-1){1'b0}}}
                            : {1'b0, {(OWIDTH-1){1'b1}}};
      end else begin
        acc_d = sum_c[OWIDTH-1:0];
      end
      cnt_d   = (&cnt_base_c) ? cnt_base_c : cnt_base_c + CWIDTH'(1);
      sat_d   = (first_q ? 1'b0 : sat_q) | ovf_c;
      first_d = lst_q[L+1];
      done_d  = lst_q[L+1];
    end
  end

  // Datapath pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= '0;
      lst_q <= '0;
      for (int i = 1; i < int'(NN); i++) node_q[i] <= '0;
    end else begin
      a_q   <= vec0;
      b_q   <= vec1;
      vld_q <= {vld_q[L:0], ivalid};
      lst_q <= {lst_q[L:0], ivalid & ilast};
      for (int i = 1; i < int'(NN); i++) node_q[i] <= node_d[i];
    end
  end

  // Accumulator state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      first_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end

  // Output stage: capture the finished group, hold otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result   <= '0;
      ovalid   <= 1'b0;
      ocount   <= '0;
      overflow <= 1'b0;
    end else begin
      ovalid <= done_q;
      if (done_q) begin
        result   <= acc_q;
        ocount   <= cnt_q;
        overflow <= sat_q;
      end
    end
  end

endmodule

// File: tb/tb_dot_acc.sv
// tb_dot_acc: directed scoreboard bench for dot_acc. Two instances share the
// stimulus: a default 32-bit one and a 20-bit one with a 2-bit beat counter
// so that result saturation and count saturation are both reached.
module tb_dot_acc;

  localparam int LAT = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [63:0]         vec0, vec1;
  logic                ivalid, ilast;

  logic signed [31:0]  res32;
  logic                ovalid32, ovf32;
  logic [15:0]         cnt32;
  logic signed [19:0]  res20;
  logic                ovalid20, ovf20;
  logic [1:0]          cnt20;

  typedef struct {
    longint res;
    longint cnt;
    longint ovf;
    longint cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q20[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  dot_acc #(.IWIDTH(8), .LANES(8), .OWIDTH(32), .CWIDTH(16)) u_dut32 (
    .clk(clk), .rst(rst), .vec0(vec0), .vec1(vec1), .ivalid(ivalid),
    .ilast(ilast), .result(res32), .ovalid(ovalid32), .ocount(cnt32),
    .overflow(ovf32)
  );

  dot_acc #(.IWIDTH(8), .LANES(8), .OWIDTH(20), .CWIDTH(2)) u_dut20 (
    .clk(clk), .rst(rst), .vec0(vec0), .vec1(vec1), .ivalid(ivalid),
    .ilast(ilast), .result(res20), .ovalid(ovalid20), .ocount(cnt20),
    .overflow(ovf20)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per ovalid pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst && ovalid32) begin
      chk("o32 pulse expected", longint'(q32.size() > 0), 1);
      if (q32.size() > 0) begin
        e = q32.pop_front();
        chk("o32 result",   longint'(res32), e.res);
        chk("o32 ocount",   longint'(cnt32), e.cnt);
        chk("o32 overflow", longint'(ovf32), e.ovf);
        chk("o32 latency",  longint'(cyc),   e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && ovalid20) begin
      chk("o20 pulse expected", longint'(q20.size() > 0), 1);
      if (q20.size() > 0) begin
        e = q20.pop_front();
        chk("o20 result",   longint'(res20), e.res);
        chk("o20 ocount",   longint'(cnt20), e.cnt);
        chk("o20 overflow", longint'(ovf20), e.ovf);
        chk("o20 latency",  longint'(cyc),   e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call just before driving the last beat of a group
  task automatic expect_grp(input longint r32, input longint c32, input longint o32,
                            input longint r20, input longint c20, input longint o20);
    exp_t e;
    e.cyc = longint'(cyc + 1 + LAT);
    e.res = r32; e.cnt = c32; e.ovf = o32;
    q32.push_back(e);
    e.res = r20; e.cnt = c20; e.ovf = o20;
    q20.push_back(e);
  endtask

  task automatic beat(input logic signed [7:0] a, input logic signed [7:0] b,
                      input logic last);
    vec0   = {8{a}};
    vec1   = {8{b}};
    ivalid = 1'b1;
    ilast  = last;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    ilast  = 1'b0;
    vec0   = '0;
    vec1   = '0;
  endtask

  task automatic grp(input logic signed [7:0] a, input logic signed [7:0] b,
                     input int n, input int gap,
                     input longint r32, input longint c32, input longint o32,
                     input longint r20, input longint c20, input longint o20);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) expect_grp(r32, c32, o32, r20, c20, o20);
      beat(a, b, i == n - 1);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " res32"},  longint'(res32),    0);
    chk({tag, " ov32v"},  longint'(ovalid32), 0);
    chk({tag, " cnt32"},  longint'(cnt32),    0);
    chk({tag, " ovf32"},  longint'(ovf32),    0);
    chk({tag, " res20"},  longint'(res20),    0);
    chk({tag, " ov20v"},  longint'(ovalid20), 0);
    chk({tag, " cnt20"},  longint'(cnt20),    0);
    chk({tag, " ovf20"},  longint'(ovf20),    0);
  endtask

  initial begin
    rst    = 1'b0;
    ivalid = 1'b0;
    ilast  = 1'b0;
    vec0   = '0;
    vec1   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    idle(1);

    // Single beat, then extremes
    grp(8'sd3, -8'sd2, 1, 0,  -48, 1, 0,  -48, 1, 0);
    idle(8);
    grp(-8'sd128, -8'sd128, 1, 0,  131072, 1, 0,  131072, 1, 0);
    grp(-8'sd128, 8'sd127,  2, 0,  -260096, 2, 0,  -260096, 2, 0);

    // Multi-beat with two idle cycles after each beat
    grp(8'sd1, 8'sd1, 3, 2,  24, 3, 0,  24, 3, 0);

    // Back-to-back groups
    grp(8'sd2, 8'sd2,  1, 0,  32, 1, 0,  32, 1, 0);
    grp(8'sd1, -8'sd1, 2, 0,  -16, 2, 0,  -16, 2, 0);

    // Saturation on the 20-bit instance; its 2-bit count saturates at 3
    grp(-8'sd128, -8'sd128, 4, 0,  524288, 4, 0,  524287, 3, 1);
    grp(-8'sd128, 8'sd127,  5, 0,  -650240, 5, 0,  -524288, 3, 1);
    grp(8'sd1, 8'sd1, 1, 0,  8, 1, 0,  8, 1, 0);

    // Accumulation continues from the clamped value
    for (int i = 0; i < 4; i++) beat(-8'sd128, -8'sd128, 1'b0);
    expect_grp(394240, 5, 0,  394239, 3, 1);
    beat(-8'sd128, 8'sd127, 1'b1);
    idle(12);

    // Reset mid-group discards partial sum and in-flight beats
    beat(8'sd1, 8'sd1, 1'b0);
    beat(8'sd1, 8'sd1, 1'b0);
    rst = 1'b0;
    #2;
    chk_zero("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    grp(8'sd1, 8'sd1, 1, 0,  8, 1, 0,  8, 1, 0);

    for (int i = 0; i < 40 && (q32.size() > 0 || q20.size() > 0); i++) idle(1);
    chk("queues drained", longint'(q32.size() + q20.size()), 0);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
